// File: rtl/beep_tone_gen.sv
// Square-wave buzzer driver: plays each note period for a fixed beat, then pulses note_adv.
// Optional articulation gap between notes is compiled in with `define BEEP_GAP_EN.
module beep_tone_gen #(
   parameter int unsigned BEAT_CYCLES = 12_500_000,
   parameter int unsigned GAP_CYCLES  = 1_250_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] period,
   output logic        beep,
   output logic        note_adv,
   output logic        playing
);

   localparam logic [31:0] BeatLast = 32'(BEAT_CYCLES - 1);

   if (BEAT_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
      $error("beep_tone_gen: BEAT_CYCLES and GAP_CYCLES must be at least 1");
   end

`ifdef BEEP_GAP_EN
   typedef enum logic [1:0] {StIdle, StLoad, StPlay, StGap} state_e;
`else
   typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;
`endif

   state_e      state_q, state_d;
   logic [31:0] per_q, per_d;
   logic [31:0] half_q, half_d;
   logic [31:0] tone_cnt_q, tone_cnt_d;
   logic [31:0] beat_cnt_q, beat_cnt_d;
   logic        beep_q, beep_d;
   logic        beat_end;
   logic        tone_wrap;

   assign beat_end  = (beat_cnt_q == BeatLast);
   // Wrapping at per-1 keeps a period of 32'hFFFF_FFFF free of overflow.
   assign tone_wrap = (tone_cnt_q == per_q - 32'd1);

`ifdef BEEP_GAP_EN
   localparam logic [31:0] GapLast = 32'(GAP_CYCLES - 1);

   logic [31:0] gap_cnt_q, gap_cnt_d;
   logic        gap_end;

   assign gap_end = (gap_cnt_q == GapLast);

   always_comb begin
      gap_cnt_d = 32'd0;
      if (state_q == StGap) begin
         gap_cnt_d = gap_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gap_cnt_q <= 32'd0;
      end else begin
         gap_cnt_q <= gap_cnt_d;
      end
   end
`endif

   // Next-state and note_adv; a dropped enable always wins over the beat end.
   always_comb begin
      state_d  = state_q;
      note_adv = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (en) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            state_d = en ? StPlay : StIdle;
         end
         StPlay: begin
            if (!en) begin
               state_d = StIdle;
            end else if (beat_end) begin
               note_adv = 1'b1;
`ifdef BEEP_GAP_EN
               state_d  = StGap;
`else
               state_d  = StLoad;
`endif
            end
         end
`ifdef BEEP_GAP_EN
         StGap: begin
            if (!en) begin
               state_d = StIdle;
            end else if (gap_end) begin
               state_d = StLoad;
            end
         end
`endif
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Tone datapath: the period is latched only in LOAD so a note never glitches.
   always_comb begin
      per_d      = per_q;
      half_d     = half_q;
      tone_cnt_d = tone_cnt_q;
      beat_cnt_d = beat_cnt_q;
      beep_d     = 1'b0;
      if (state_q == StLoad) begin
         per_d      = period;
         half_d     = period >> 1;
         tone_cnt_d = 32'd0;
         beat_cnt_d = 32'd0;
      end else if (state_q == StPlay) begin
         beat_cnt_d = beat_cnt_q + 32'd1;
         tone_cnt_d = tone_wrap ? 32'd0 : tone_cnt_q + 32'd1;
         beep_d     = en && !beat_end && (per_q >= 32'd2) && (tone_cnt_q < half_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         per_q      <= 32'd0;
         half_q     <= 32'd0;
         tone_cnt_q <= 32'd0;
         beat_cnt_q <= 32'd0;
         beep_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         per_q      <= per_d;
         half_q     <= half_d;
         tone_cnt_q <= tone_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         beep_q     <= beep_d;
      end
   end

   assign beep    = beep_q;
   assign playing = (state_q != StIdle);

endmodule
